// File: rtl/sys_reset_pkg.sv
// ============================================================================
// sys_reset_pkg : state encodings and default cycle counts for sys_reset_seq
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

package sys_reset_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_MEM       = 3'd2,
    S_SYS       = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int CLK_HZ = 80_000_000;

  // Cycle counts derived from the 80 MHz fabric clock
  localparam int DEF_LOCK_STABLE_CYCLES = 65536;              // ~0.8 ms
  localparam int DEF_MEM_TIMEOUT_CYCLES = CLK_HZ / 2000;      // 500 us
  localparam int DEF_CPU_DELAY_CYCLES   = 1024;
  localparam int DEF_DEBOUNCE_CYCLES    = CLK_HZ / 100;       // 10 ms
  localparam int DEF_CNT_W              = 20;

endpackage

`default_nettype wire

// File: rtl/sys_reset_seq_sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser with selectable reset value
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_reset_seq.sv
// ============================================================================
// sys_reset_seq : staged SDRAM -> system -> CPU reset release for 80 MHz domain
// Optional macro RESET_BTN_DEBOUNCE_EN adds a debounced, one-shot reset button.
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module sys_reset_seq
  import sys_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int MEM_TIMEOUT_CYCLES = DEF_MEM_TIMEOUT_CYCLES,
  parameter int CPU_DELAY_CYCLES   = DEF_CPU_DELAY_CYCLES,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       btn_reset_n,
  input  logic       mem_ready,
  output logic       mem_rst_n,
  output logic       sys_rst_n,
  output logic       cpu_rst_n,
  output logic       ready,
  output logic       mem_fault,
  output logic [2:0] state
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (LOCK_STABLE_CYCLES < 1 || longint'(LOCK_STABLE_CYCLES) >= CNT_LIMIT ||
      MEM_TIMEOUT_CYCLES < 1 || longint'(MEM_TIMEOUT_CYCLES) >= CNT_LIMIT ||
      CPU_DELAY_CYCLES   < 1 || longint'(CPU_DELAY_CYCLES)   >= CNT_LIMIT ||
      DEBOUNCE_CYCLES    < 1 || longint'(DEBOUNCE_CYCLES)    >= CNT_LIMIT) begin : g_bad_params
    $error("sys_reset_seq: cycle parameters must be in [1, 2**CNT_W)");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY_CYCLES - 1);

  logic lock_s, btn_s, btn_trig, btn_hit;
  state_t cur_state, nxt_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic fault_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_lock (
    .clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s)
  );

  sync_2ff #(.RST_VAL(1'b1)) u_sync_btn (
    .clk(clk), .rst_n(rst_n), .d(btn_reset_n), .q(btn_s)
  );

`ifdef RESET_BTN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt;
  logic deb_armed;

  // One trigger per press: disarmed after firing until a high sample is seen
  assign btn_trig = !btn_s && deb_armed && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_armed <= 1'b1;
    end else if (btn_s) begin
      deb_cnt   <= '0;
      deb_armed <= 1'b1;
    end else begin
      if (deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + CNT_W'(1);
      if (btn_trig) deb_armed <= 1'b0;
    end
  end
`else
  assign btn_trig = !btn_s;
`endif

  always_comb begin
    nxt_state = cur_state;
    fault_nxt = mem_fault;
    btn_hit   = 1'b0;
    cnt_nxt   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    if (!lock_s) begin
      nxt_state = S_WAIT_LOCK;
    end else if (btn_trig && (cur_state == S_SYS || cur_state == S_RUN)) begin
      nxt_state = S_SYS;
      btn_hit   = 1'b1;
    end else begin
      case (cur_state)
        S_WAIT_LOCK: nxt_state = S_STABLE;
        S_STABLE:    if (cnt == LOCK_LAST) nxt_state = S_MEM;
        S_MEM: begin
          // mem_ready takes precedence over a coincident timeout
          if (mem_ready) begin
            nxt_state = S_SYS;
            fault_nxt = 1'b0;
          end else if (cnt == MEM_LAST) begin
            nxt_state = S_WAIT_LOCK;
            fault_nxt = 1'b1;
          end
        end
        S_SYS:       if (cnt == CPU_LAST) nxt_state = S_RUN;
        S_RUN:       nxt_state = S_RUN;
        default:     nxt_state = S_WAIT_LOCK;
      endcase
    end

    if (nxt_state != cur_state || btn_hit) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_WAIT_LOCK;
      cnt       <= '0;
      mem_rst_n <= 1'b0;
      sys_rst_n <= 1'b0;
      cpu_rst_n <= 1'b0;
      ready     <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      mem_rst_n <= (nxt_state == S_MEM) || (nxt_state == S_SYS) || (nxt_state == S_RUN);
      sys_rst_n <= ((nxt_state == S_SYS) || (nxt_state == S_RUN)) && !btn_hit;
      cpu_rst_n <= (nxt_state == S_RUN);
      ready     <= (nxt_state == S_RUN);
      mem_fault <= fault_nxt;
    end
  end

  assign state = cur_state;

endmodule

`default_nettype wire
